// File: rtl/starflux_pkg.sv
//==============================================================================
// Module      : starflux_pkg
// Description : Shared types and screen constants for the bullet/enemy logic.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package starflux_pkg;

    // Hit-detector control states.
    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        TRACK   = 2'd1,
        EXPLODE = 2'd2,
        RELOAD  = 2'd3
    } state_t;

    localparam int COORD_W  = 8;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [COORD_W-1:0] DEF_ENEMY_Y      = 8'd100;
    localparam logic [COORD_W-1:0] DEF_BULLET_Y_MAX = 8'd119;

    // Combo multiplier width; the counter saturates at all-ones (7).
    localparam int COMBO_W = 3;

    // Saturating increment of the combo counter.
    function automatic logic [COMBO_W-1:0] combo_next(input logic [COMBO_W-1:0] c);
        return (c == {COMBO_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_hold_counter.sv
//==============================================================================
// Module      : tick_hold_counter
// Description : Loadable down-counter stepped by the movement tick, with a
//               zero flag. Stops at zero; a load has priority over a tick.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tick_hold_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: load wins, otherwise decrement on tick until zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/bullet_hit_detector.sv
//==============================================================================
// Module      : bullet_hit_detector
// Description : Compares the player's bullet against the enemy sprite, pulses
//               hit/miss, requests bullet reloads, blanks the enemy during the
//               explosion hold and keeps a saturating score.
//               Optional build macro STARFLUX_COMBO_EN: hits add a growing
//               combo value (1..7) instead of 1; a miss resets the combo.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module bullet_hit_detector
    import starflux_pkg::*;
#(
    parameter logic [COORD_W-1:0] ENEMY_Y      = DEF_ENEMY_Y,
    parameter int                 ENEMY_W      = 8,
    parameter logic [COORD_W-1:0] BULLET_Y_MAX = DEF_BULLET_Y_MAX,
    parameter int                 HIT_HOLD     = 4,
    parameter int                 SCORE_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               bullet_valid,
    input  logic [7:0]         x_val_bullet,
    input  logic [7:0]         y_val_bullet,
    input  logic [7:0]         x_val_enemy,
    output logic               hit,
    output logic               miss,
    output logic               bullet_clear,
    output logic               enemy_visible,
    output logic [SCORE_W-1:0] score
);

    // A zero hold still blanks the enemy for one tick.
    localparam int HOLD_EFF = (HIT_HOLD < 1) ? 1 : HIT_HOLD;
    localparam int HOLD_W   = $clog2(HOLD_EFF + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_EFF);
    // Window arithmetic is one bit wider so x_enemy+W-1 cannot wrap.
    localparam logic [COORD_W:0]   WIN_SPAN  = (COORD_W+1)'(ENEMY_W - 1);

    state_t             state_d, state_q;
    logic               hit_d, hit_q;
    logic               miss_d, miss_q;
    logic               bullet_clear_d, bullet_clear_q;
    logic               enemy_visible_d, enemy_visible_q;
    logic [SCORE_W-1:0] score_d, score_q;

    logic [COORD_W:0]   bullet_x_ext;
    logic [COORD_W:0]   win_lo;
    logic [COORD_W:0]   win_hi;
    logic               in_window;
    logic               is_hit;
    logic               is_miss;
    logic [COMBO_W-1:0] score_inc;
    logic [SCORE_W:0]   score_sum;
    logic               hold_load;
    logic [HOLD_W-1:0]  hold_count;
    logic               hold_zero;
    logic               explode_done;

`ifdef STARFLUX_COMBO_EN
    logic [COMBO_W-1:0] combo_d, combo_q;
    // Each hit scores the post-increment combo value.
    assign score_inc = combo_next(combo_q);
`else
    assign score_inc = COMBO_W'(1);
`endif

    assign bullet_x_ext = {1'b0, x_val_bullet};
    assign win_lo       = {1'b0, x_val_enemy};
    assign win_hi       = win_lo + WIN_SPAN;
    assign in_window    = (bullet_x_ext >= win_lo) && (bullet_x_ext <= win_hi);
    assign is_hit       = in_window && (y_val_bullet == ENEMY_Y);
    assign is_miss      = (y_val_bullet >= BULLET_Y_MAX);
    assign score_sum    = {1'b0, score_q} + (SCORE_W+1)'(score_inc);
    // The hold ends on the tick that takes the counter from 1 to 0.
    assign explode_done = tick && (hold_zero || (hold_count == HOLD_W'(1)));

    // Explosion hold timer, only stepped while exploding.
    tick_hold_counter #(
        .WIDTH (HOLD_W)
    ) u_hold (
        .clock    (clock),
        .reset    (reset),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .tick     (tick && (state_q == EXPLODE)),
        .count    (hold_count),
        .zero     (hold_zero)
    );

    // Next-state, pulse and score logic; level outputs follow the next state.
    always_comb begin
        state_d   = state_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        score_d   = score_q;
        hold_load = 1'b0;
`ifdef STARFLUX_COMBO_EN
        combo_d   = combo_q;
`endif
        case (state_q)
            ARMED: begin
                if (bullet_valid) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (!bullet_valid) begin
                    state_d = ARMED;
                end else if (tick) begin
                    // Hit takes priority when both conditions hold.
                    if (is_hit) begin
                        state_d   = EXPLODE;
                        hit_d     = 1'b1;
                        hold_load = 1'b1;
                        score_d   = score_sum[SCORE_W] ? {SCORE_W{1'b1}}
                                                       : score_sum[SCORE_W-1:0];
`ifdef STARFLUX_COMBO_EN
                        combo_d   = score_inc;
`endif
                    end else if (is_miss) begin
                        state_d = RELOAD;
                        miss_d  = 1'b1;
`ifdef STARFLUX_COMBO_EN
                        combo_d = '0;
`endif
                    end
                end
            end
            EXPLODE: begin
                if (explode_done) begin
                    state_d = RELOAD;
                end
            end
            RELOAD: begin
                if (!bullet_valid) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
        bullet_clear_d  = (state_d == EXPLODE) || (state_d == RELOAD);
        enemy_visible_d = (state_d != EXPLODE);
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ARMED;
            hit_q           <= 1'b0;
            miss_q          <= 1'b0;
            bullet_clear_q  <= 1'b0;
            enemy_visible_q <= 1'b1;
            score_q         <= '0;
`ifdef STARFLUX_COMBO_EN
            combo_q         <= '0;
`endif
        end else begin
            state_q         <= state_d;
            hit_q           <= hit_d;
            miss_q          <= miss_d;
            bullet_clear_q  <= bullet_clear_d;
            enemy_visible_q <= enemy_visible_d;
            score_q         <= score_d;
`ifdef STARFLUX_COMBO_EN
            combo_q         <= combo_d;
`endif
        end
    end

    assign hit           = hit_q;
    assign miss          = miss_q;
    assign bullet_clear  = bullet_clear_q;
    assign enemy_visible = enemy_visible_q;
    assign score         = score_q;

endmodule

`default_nettype wire

// File: tb/tb_bullet_hit_detector.sv
//==============================================================================
// Module      : tb_bullet_hit_detector
// Description : Directed self-checking bench for bullet_hit_detector. A second
//               instance with a 4-bit score shares the stimulus so score
//               saturation is reached in a short run.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bullet_hit_detector;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       bullet_valid;
    logic [7:0] xb, yb, xe;

    logic        hit, miss, bullet_clear, enemy_visible;
    logic [15:0] score;
    logic        s_hit, s_miss, s_clear, s_vis;
    logic [3:0]  s_score;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_score = 0;
    int exp_small = 0;
    int exp_combo = 0;

    bullet_hit_detector dut (
        .clock         (clock),
        .reset         (reset),
        .tick          (tick),
        .bullet_valid  (bullet_valid),
        .x_val_bullet  (xb),
        .y_val_bullet  (yb),
        .x_val_enemy   (xe),
        .hit           (hit),
        .miss          (miss),
        .bullet_clear  (bullet_clear),
        .enemy_visible (enemy_visible),
        .score         (score)
    );

    bullet_hit_detector #(.SCORE_W(4)) dut_sat (
        .clock         (clock),
        .reset         (reset),
        .tick          (tick),
        .bullet_valid  (bullet_valid),
        .x_val_bullet  (xb),
        .y_val_bullet  (yb),
        .x_val_enemy   (xe),
        .hit           (s_hit),
        .miss          (s_miss),
        .bullet_clear  (s_clear),
        .enemy_visible (s_vis),
        .score         (s_score)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference scoring for one hit.
    task automatic model_hit();
        int inc;
`ifdef STARFLUX_COMBO_EN
        if (exp_combo < 7) exp_combo++;
        inc = exp_combo;
`else
        inc = 1;
`endif
        exp_score = (exp_score + inc > 65535) ? 65535 : exp_score + inc;
        exp_small = (exp_small + inc > 15) ? 15 : exp_small + inc;
    endtask

    // Hold phase after a hit pulse: 4 ticks blanked, then RELOAD until withdrawn.
    task automatic explode_seq(input string tag);
        tick = 1'b1;
        step();
        check({tag, "_pulse_once"}, 32'(hit), 0);
        check({tag, "_vis_t1"}, 32'(enemy_visible), 0);
        step();
        step();
        check({tag, "_vis_t3"}, 32'(enemy_visible), 0);
        step();
        check({tag, "_vis_reload"}, 32'(enemy_visible), 1);
        check({tag, "_clr_reload"}, 32'(bullet_clear), 1);
        tick = 1'b0;
        step();
        check({tag, "_clr_hold"}, 32'(bullet_clear), 1);
        bullet_valid = 1'b0;
        step();
        check({tag, "_clr_armed"}, 32'(bullet_clear), 0);
    endtask

    // Arm a bullet, present it at the enemy row and check the outcome.
    task automatic shoot(input string tag, input logic [7:0] e, input logic [7:0] b, input bit exp_hit);
        xe = e; xb = b; yb = 8'd60; tick = 1'b1; bullet_valid = 1'b1;
        step();
        yb = 8'd100; tick = 1'b0;
        step();
        check({tag, "_notick"}, 32'(hit), 0);
        tick = 1'b1;
        step();
        check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        check({tag, "_shit"}, 32'(s_hit), 32'(exp_hit));
        check({tag, "_miss"}, 32'(miss), 0);
        if (exp_hit) begin
            model_hit();
            check({tag, "_score"}, 32'(score), exp_score);
            check({tag, "_sscore"}, 32'(s_score), exp_small);
            check({tag, "_vis"}, 32'(enemy_visible), 0);
            check({tag, "_svis"}, 32'(s_vis), 0);
            check({tag, "_clr"}, 32'(bullet_clear), 1);
            explode_seq(tag);
        end else begin
            bullet_valid = 1'b0; tick = 1'b0;
            step();
            check({tag, "_score"}, 32'(score), exp_score);
            check({tag, "_clr"}, 32'(bullet_clear), 0);
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; bullet_valid = 1'b0;
        xb = 8'd0; yb = 8'd0; xe = 8'd0;
        step();
        step();
        check("rst_hit", 32'(hit), 0);
        check("rst_miss", 32'(miss), 0);
        check("rst_clr", 32'(bullet_clear), 0);
        check("rst_vis", 32'(enemy_visible), 1);
        check("rst_score", 32'(score), 0);
        reset = 1'b0;
        step();

        // Direct hit and window edges.
        shoot("direct", 8'd40, 8'd43, 1'b1);
        shoot("left_out", 8'd40, 8'd39, 1'b0);
        shoot("right_out", 8'd40, 8'd48, 1'b0);
        shoot("left_in", 8'd40, 8'd40, 1'b1);
        shoot("right_in", 8'd40, 8'd47, 1'b1);
        shoot("edge_255", 8'd250, 8'd255, 1'b1);
        shoot("no_wrap", 8'd250, 8'd1, 1'b0);

        // Miss: bullet climbs to the bottom edge.
        xe = 8'd100; xb = 8'd10; yb = 8'd60; tick = 1'b1; bullet_valid = 1'b1;
        step();
        for (int y = 110; y < 119; y++) begin
            yb = 8'(y);
            step();
        end
        check("miss_early", 32'(miss), 0);
        yb = 8'd119;
        step();
        model_hit_skip: begin end
        check("miss_pulse", 32'(miss), 1);
        check("miss_spulse", 32'(s_miss), 1);
        check("miss_nohit", 32'(hit), 0);
        check("miss_score", 32'(score), exp_score);
        check("miss_clr", 32'(bullet_clear), 1);
        check("miss_sclr", 32'(s_clear), 1);
        exp_combo = 0;
        yb = 8'd120;
        step();
        check("miss_once", 32'(miss), 0);
        bullet_valid = 1'b0;
        step();
        check("miss_rearm", 32'(bullet_clear), 0);

        // First hit after a miss restarts the combo.
        shoot("after_miss", 8'd40, 8'd44, 1'b1);

        // Bullet withdrawn in TRACK before reaching the enemy row.
        xe = 8'd40; xb = 8'd43; yb = 8'd60; tick = 1'b1; bullet_valid = 1'b1;
        step();
        yb = 8'd80;
        step();
        bullet_valid = 1'b0; yb = 8'd100;
        step();
        check("wd_hit", 32'(hit), 0);
        check("wd_miss", 32'(miss), 0);
        check("wd_score", 32'(score), exp_score);
        check("wd_clr", 32'(bullet_clear), 0);

        // Asynchronous reset while the hit pulse is showing.
        xe = 8'd40; xb = 8'd43; yb = 8'd60; tick = 1'b1; bullet_valid = 1'b1;
        step();
        yb = 8'd100;
        step();
        check("pre_rst_hit", 32'(hit), 1);
        reset = 1'b1;
        #1;
        check("arst_hit", 32'(hit), 0);
        check("arst_vis", 32'(enemy_visible), 1);
        check("arst_clr", 32'(bullet_clear), 0);
        check("arst_score", 32'(score), 0);
        #1;
        reset = 1'b0;
        exp_score = 0; exp_small = 0; exp_combo = 0;
        // Bullet already at the hit spot: ARMED must not compare.
        step();
        check("armed_nocmp", 32'(hit), 0);
        step();
        check("post_rst_hit", 32'(hit), 1);
        model_hit();
        check("post_rst_score", 32'(score), exp_score);
        explode_seq("post_rst");

        // Run the narrow score into saturation.
        for (int i = 0; i < 17; i++) begin
            shoot("sat", 8'd40, 8'd44, 1'b1);
        end
        check("sat_final", 32'(s_score), 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
